// File: rtl/ib.sv
// ib: two-VC router input buffer. Each VC has its own DEPTH-entry flit FIFO.
// A packet controller picks a VC holding a head flit, requests the crossbar
// port named in the head, then streams the packet until its tail. Every freed
// FIFO entry is returned upstream as a one-cycle credit pulse.
module ib #(
  parameter int DATAW = 31,
  parameter int VCHW  = 0,
  parameter int PORTW = 2,
  parameter int PORT  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   in_data,
  input  logic             in_valid,
  input  logic [VCHW:0]    in_vch,
  output logic             ocredit,
  output logic [VCHW:0]    ocredit_vch,
  output logic [DATAW:0]   cb_data,
  output logic             cb_valid,
  output logic [VCHW:0]    cb_vch,
  output logic [PORTW:0]   cb_port,
  output logic             cb_req,
  input  logic [PORT:0]    cb_grt,
  output logic             err
);
  localparam int NVC = 2;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int VW  = VCHW + 1;
  localparam int PW  = PORTW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;
  state_t state, state_nxt;

  logic [NVC-1:0][DATAW:0] front;
  logic [NVC-1:0]          nempty, full, push, pop;
  logic                    in_vc, rr_ptr, vc_sel;
  logic [PORTW:0]          port_reg;
  logic                    cand_any, cand_vc, cand_ok;
  logic [31:0]             cand_dest;
  logic                    grt_hit, start, discard, xfer_tail, ovf;

  // Two VCs only, so the low VC-ID bit selects the FIFO.
  assign in_vc = in_vch[0];

  // Per-VC flit FIFO; a push into a full FIFO is accepted only if the
  // same edge also pops it.
  for (genvar v = 0; v < NVC; v++) begin : g_vc
    logic [DATAW:0] mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [CW-1:0]  cnt;

    assign front[v]  = mem[rp];
    assign nempty[v] = (cnt != '0);
    assign full[v]   = (cnt == CW'(DEPTH));
    assign push[v]   = in_valid && (in_vc == 1'(v)) && (!full[v] || pop[v]);

    // Storage array: contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
      if (push[v]) mem[wp] <= in_data;
    end

    // Pointers wrap modulo DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push[v]) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pop[v])  rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        cnt <= cnt + CW'(push[v]) - CW'(pop[v]);
      end
    end
  end

  // Idle-time candidate: pointer VC first, else the other VC; it is only
  // startable when its front flit is a head with a reachable destination.
  always_comb begin
    cand_any  = nempty[rr_ptr] | nempty[~rr_ptr];
    cand_vc   = nempty[rr_ptr] ? rr_ptr : ~rr_ptr;
    cand_dest = 32'(front[cand_vc][PORTW:0]);
    cand_ok   = front[cand_vc][DATAW-1] && (cand_dest <= 32'(PORT));
  end

  // Grant bit of the latched port, written as a compare loop so the port
  // field width need not match the grant vector index width.
  always_comb begin
    grt_hit = 1'b0;
    for (int p = 0; p <= PORT; p++)
      if (port_reg == PW'(p)) grt_hit = cb_grt[p];
  end

  // State register.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: start on a good head, leave REQ on grant, finish on tail pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (xfer_tail) state_nxt = IDLE;
               else if (grt_hit) state_nxt = XFER;
      XFER:    if (xfer_tail) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs and pop control. Data leaves only while granted and the selected
  // FIFO holds a flit; an empty FIFO mid-packet just produces a bubble.
  always_comb begin
    cb_req   = 1'b0;
    cb_port  = '0;
    cb_vch   = '0;
    cb_valid = 1'b0;
    cb_data  = '0;
    start    = 1'b0;
    discard  = 1'b0;
    pop      = '0;
    case (state)
      IDLE: begin
        if (cand_any) begin
          start        = cand_ok;
          discard      = !cand_ok;
          pop[cand_vc] = !cand_ok;
        end
      end
      REQ, XFER: begin
        cb_req      = 1'b1;
        cb_port     = port_reg;
        cb_vch      = VW'(vc_sel);
        cb_valid    = grt_hit && nempty[vc_sel];
        cb_data     = cb_valid ? front[vc_sel] : '0;
        pop[vc_sel] = cb_valid;
      end
      default: ;
    endcase
  end

  assign xfer_tail = cb_valid && front[vc_sel][DATAW];
  assign ovf       = in_valid && full[in_vc] && !pop[in_vc];

  // Packet context, round-robin pointer, sticky error and registered credit.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rr_ptr      <= 1'b0;
      vc_sel      <= 1'b0;
      port_reg    <= '0;
      err         <= 1'b0;
      ocredit     <= 1'b0;
      ocredit_vch <= '0;
    end else begin
      if (start) begin
        vc_sel   <= cand_vc;
        port_reg <= front[cand_vc][PORTW:0];
      end
      if (xfer_tail) rr_ptr <= ~rr_ptr;
      if (ovf || discard) err <= 1'b1;
      ocredit     <= |pop;
      ocredit_vch <= VW'(pop[1]);
    end
  end

endmodule

// File: tb/tb_ib.sv
// tb_ib: directed scenarios plus random traffic, all checked every cycle
// against a queue-level model of the input buffer.
module tb_ib;
  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [0:0]  in_vch = '0;
  logic [4:0]  cb_grt = '0;
  logic        ocredit, cb_valid, cb_req, err;
  logic [0:0]  ocredit_vch, cb_vch;
  logic [31:0] cb_data;
  logic [2:0]  cb_port;

  ib dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid), .in_vch(in_vch),
    .ocredit(ocredit), .ocredit_vch(ocredit_vch), .cb_data(cb_data), .cb_valid(cb_valid),
    .cb_vch(cb_vch), .cb_port(cb_port), .cb_req(cb_req), .cb_grt(cb_grt), .err(err)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-VC flit lists, a busy flag for "packet in progress".
  logic [31:0] mbuf [2][16];
  int          mcnt [2], mrd [2], mwr [2];
  int          mvc, mptr, mcvc;
  logic        mbusy, merr, mcred;
  logic [2:0]  mport;

  // Observation counters for the directed scenarios.
  int          nvalid, ncred, nreq, nlog;
  logic [31:0] dlog [64];
  logic [0:0]  lastvch;
  logic [2:0]  lastport;

  task automatic mreset;
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mrd[i] = 0; mwr[i] = 0;
    end
    mbusy = 1'b0; merr = 1'b0; mcred = 1'b0;
    mvc = 0; mptr = 0; mcvc = 0; mport = '0;
  endtask

  // Compare process: check current outputs, then advance the model past
  // the coming rising edge.
  always @(negedge clk) begin : cmp
    logic [31:0] f;
    int          v, pcv;
    logic        ev, pcred;
    #2;
    if (rst_) begin
      mreset();
      chk("rst_cb_req", cb_req, 0);
      chk("rst_cb_valid", cb_valid, 0);
      chk("rst_cb_data", cb_data, 0);
      chk("rst_cb_vch", cb_vch, 0);
      chk("rst_cb_port", cb_port, 0);
      chk("rst_ocredit", ocredit, 0);
      chk("rst_ocredit_vch", ocredit_vch, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("ocredit", ocredit, mcred);
      chk("ocredit_vch", ocredit_vch, mcred ? mcvc : 0);
      chk("err", err, merr);
      pcred = 1'b0; pcv = 0;
      if (!mbusy) begin
        chk("cb_req", cb_req, 0);
        chk("cb_valid", cb_valid, 0);
        chk("cb_port", cb_port, 0);
        chk("cb_vch", cb_vch, 0);
        chk("cb_data", cb_data, 0);
        v = (mcnt[mptr] > 0) ? mptr : ((mcnt[1-mptr] > 0) ? 1 - mptr : -1);
        if (v >= 0) begin
          f = mbuf[v][mrd[v] % 16];
          if (f[30] && f[2:0] <= 3'd4) begin
            mbusy = 1'b1; mvc = v; mport = f[2:0];
          end else begin
            mrd[v]++; mcnt[v]--; merr = 1'b1; pcred = 1'b1; pcv = v;
          end
        end
      end else begin
        chk("cb_req", cb_req, 1);
        chk("cb_port", cb_port, mport);
        chk("cb_vch", cb_vch, mvc);
        ev = cb_grt[mport] && (mcnt[mvc] > 0);
        chk("cb_valid", cb_valid, ev);
        f = ev ? mbuf[mvc][mrd[mvc] % 16] : 32'd0;
        chk("cb_data", cb_data, f);
        if (ev) begin
          mrd[mvc]++; mcnt[mvc]--; pcred = 1'b1; pcv = mvc;
          if (f[31]) begin mbusy = 1'b0; mptr = 1 - mptr; end
        end
      end
      if (in_valid) begin
        v = in_vch;
        if (mcnt[v] < 4) begin
          mbuf[v][mwr[v] % 16] = in_data; mwr[v]++; mcnt[v]++;
        end else merr = 1'b1;
      end
      mcred = pcred; mcvc = pcv;
      if (cb_valid) begin
        dlog[nlog % 64] = cb_data; nlog++; nvalid++;
        lastvch = cb_vch; lastport = cb_port;
      end
      if (ocredit) ncred++;
      if (cb_req) nreq++;
    end
  end

  function automatic logic [31:0] fl(input logic [1:0] t, input logic [2:0] d, input logic [7:0] tag);
    return {t, 19'd0, tag, d};
  endfunction

  task automatic step(input logic iv, input logic [31:0] d, input logic vc, input logic [4:0] g);
    @(negedge clk);
    in_valid = iv; in_data = d; in_vch = vc; cb_grt = g;
  endtask

  task automatic idle(input int n, input logic [4:0] g);
    repeat (n) step(1'b0, 32'd0, 1'b0, g);
  endtask

  task automatic clr;
    nvalid = 0; ncred = 0; nreq = 0; nlog = 0;
  endtask

  initial begin
    clr();
    repeat (2) @(negedge clk);
    rst_ = 1'b0;

    // Single head+tail flit on VC0 to port 3.
    clr();
    step(1'b1, fl(2'b11, 3'd3, 8'd1), 1'b0, 5'b01000);
    idle(5, 5'b01000);
    #3;
    chk("single_nvalid", nvalid, 1);
    chk("single_port", lastport, 3);
    chk("single_ncred", ncred, 1);
    chk("single_flit", dlog[0], fl(2'b11, 3'd3, 8'd1));
    chk("single_req_end", cb_req, 0);

    // Pointer now VC1. VC1 packet X in flight while VC0 and VC1 packets
    // queue up; after X the pointer is VC0, so VC0 goes next, then VC1.
    clr();
    step(1'b1, fl(2'b01, 3'd1, 8'd30), 1'b1, 5'b00000);
    step(1'b1, fl(2'b01, 3'd2, 8'd10), 1'b0, 5'b00000);
    step(1'b1, fl(2'b10, 3'd0, 8'd11), 1'b0, 5'b00000);
    step(1'b1, fl(2'b10, 3'd0, 8'd31), 1'b1, 5'b00000);
    step(1'b1, fl(2'b11, 3'd3, 8'd20), 1'b1, 5'b00000);
    idle(12, 5'b11111);
    #3;
    chk("rr_nvalid", nvalid, 5);
    chk("rr_0", dlog[0], fl(2'b01, 3'd1, 8'd30));
    chk("rr_1", dlog[1], fl(2'b10, 3'd0, 8'd31));
    chk("rr_2", dlog[2], fl(2'b01, 3'd2, 8'd10));
    chk("rr_3", dlog[3], fl(2'b10, 3'd0, 8'd11));
    chk("rr_4", dlog[4], fl(2'b11, 3'd3, 8'd20));

    // 3-flit VC1 packet to port 1, grant withheld for two request cycles.
    clr();
    step(1'b1, fl(2'b01, 3'd1, 8'd2), 1'b1, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd3), 1'b1, 5'b00000);
    step(1'b1, fl(2'b10, 3'd0, 8'd4), 1'b1, 5'b00000);
    idle(1, 5'b00000);
    idle(6, 5'b00010);
    #3;
    chk("pkt3_nvalid", nvalid, 3);
    chk("pkt3_wait", nreq - nvalid, 2);
    chk("pkt3_vch", lastvch, 1);
    chk("pkt3_f0", dlog[0], fl(2'b01, 3'd1, 8'd2));
    chk("pkt3_f1", dlog[1], fl(2'b00, 3'd0, 8'd3));
    chk("pkt3_f2", dlog[2], fl(2'b10, 3'd0, 8'd4));

    // Five pushes into VC0 with no grant: the fifth is dropped.
    clr();
    step(1'b1, fl(2'b01, 3'd4, 8'd40), 1'b0, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd41), 1'b0, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd42), 1'b0, 5'b00000);
    step(1'b1, fl(2'b10, 3'd0, 8'd43), 1'b0, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd44), 1'b0, 5'b00000);
    idle(8, 5'b10000);
    #3;
    chk("ovf_err", err, 1);
    chk("ovf_nvalid", nvalid, 4);
    chk("ovf_f0", dlog[0], fl(2'b01, 3'd4, 8'd40));
    chk("ovf_f3", dlog[3], fl(2'b10, 3'd0, 8'd43));

    // Reset in the middle of a buffered packet.
    clr();
    step(1'b1, fl(2'b01, 3'd1, 8'd70), 1'b0, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd71), 1'b0, 5'b00000);
    step(1'b1, fl(2'b00, 3'd0, 8'd72), 1'b0, 5'b00010);
    @(negedge clk);
    in_valid = 1'b0;
    rst_ = 1'b1;
    #3;
    chk("mrst_cb_req", cb_req, 0);
    chk("mrst_cb_valid", cb_valid, 0);
    chk("mrst_err", err, 0);
    chk("mrst_ocredit", ocredit, 0);
    @(negedge clk);
    rst_ = 1'b0;
    clr();
    step(1'b1, fl(2'b11, 3'd1, 8'd60), 1'b0, 5'b00010);
    idle(5, 5'b00010);
    #3;
    chk("post_rst_nvalid", nvalid, 1);
    chk("post_rst_flit", dlog[0], fl(2'b11, 3'd1, 8'd60));
    chk("post_rst_ncred", ncred, 1);

    // Head to nonexistent port 6: discarded with error and credit.
    clr();
    step(1'b1, fl(2'b01, 3'd6, 8'd50), 1'b0, 5'b11111);
    idle(4, 5'b11111);
    #3;
    chk("bad_err", err, 1);
    chk("bad_ncred", ncred, 1);
    chk("bad_nreq", nreq, 0);
    chk("bad_nvalid", nvalid, 0);

    // Random traffic with occasional resets.
    repeat (3000) begin
      @(negedge clk);
      rst_     = ($urandom_range(0, 399) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_vch   = 1'($urandom_range(0, 1));
      in_data  = {2'($urandom_range(0, 3)), 27'($urandom), 3'($urandom_range(0, 5))};
      cb_grt   = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    rst_ = 1'b0;
    idle(60, 5'b11111);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
